// File: rtl/sccb_cfg_sequencer_if.sv
// SCCB write-request bus between the configuration sequencer and the shared
// SCCB master. The sequencer holds reg_addr/wdata stable while req is high;
// the master answers each request with a one-cycle done pulse, with nack
// qualified by done.
interface sccb_cfg_sequencer_if;
  logic        sccb_req;
  logic [15:0] sccb_reg_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_done;
  logic        sccb_nack;

  // Sequencer side: issues write requests, receives completion status.
  modport master (
    output sccb_req,
    output sccb_reg_addr,
    output sccb_wdata,
    input  sccb_done,
    input  sccb_nack
  );

  // SCCB master side: accepts write requests, reports completion status.
  modport slave (
    input  sccb_req,
    input  sccb_reg_addr,
    input  sccb_wdata,
    output sccb_done,
    output sccb_nack
  );
endinterface

// File: rtl/sccb_cfg_sequencer.sv
// Camera register-table sequencer.
// After start, walks a synchronous ROM of {reg_addr[15:0], reg_data[7:0]}
// entries and issues each one as an SCCB write. Two reserved addresses act as
// markers: 16'hFFFF ends the table, 16'hFFFE inserts a wait of reg_data ms.
// The table also ends after the last ROM address without wrapping.
// Completion is reported on cfg_done, a failed write on cfg_err/err_addr;
// both are terminal until rst.
//
// Build option: define SCCB_RETRY_EN to re-issue a NACKed entry up to
// MAX_RETRY extra times before failing. Without it the first NACK fails the
// configuration and no retry counter exists.
module sccb_cfg_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int MS_CYC    = 100_000,
  parameter int MAX_RETRY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [23:0]            rom_data,
  sccb_cfg_sequencer_if.master   sccb,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic [ADDR_W-1:0]      err_addr
);

  localparam int                MS_W       = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam logic [MS_W-1:0]   MS_LAST    = MS_W'(MS_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [15:0]       END_MARK   = 16'hFFFF;
  localparam logic [15:0]       DELAY_MARK = 16'hFFFE;

`ifdef SCCB_RETRY_EN
  localparam int                 RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
`endif

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    RETRY_GAP,
    WAIT_MS,
    NEXT,
    DONE,
    ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic [15:0]       reg_addr_reg, reg_addr_next;
  logic [7:0]        wdata_reg, wdata_next;
  logic [MS_W-1:0]   ms_cnt_reg, ms_cnt_next;
  logic [7:0]        delay_cnt_reg, delay_cnt_next;
  logic [ADDR_W-1:0] err_addr_reg, err_addr_next;
`ifdef SCCB_RETRY_EN
  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
`endif

  // The entry fields as they arrive from the ROM in DECODE.
  logic [15:0] entry_addr;
  logic [7:0]  entry_data;
  assign entry_addr = rom_data[23:8];
  assign entry_data = rom_data[7:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: table pointer, current entry, wait and retry counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_reg  <= '0;
      reg_addr_reg  <= '0;
      wdata_reg     <= '0;
      ms_cnt_reg    <= '0;
      delay_cnt_reg <= '0;
      err_addr_reg  <= '0;
`ifdef SCCB_RETRY_EN
      retry_cnt_reg <= '0;
`endif
    end else begin
      rom_addr_reg  <= rom_addr_next;
      reg_addr_reg  <= reg_addr_next;
      wdata_reg     <= wdata_next;
      ms_cnt_reg    <= ms_cnt_next;
      delay_cnt_reg <= delay_cnt_next;
      err_addr_reg  <= err_addr_next;
`ifdef SCCB_RETRY_EN
      retry_cnt_reg <= retry_cnt_next;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next     = state_reg;
    rom_addr_next  = rom_addr_reg;
    reg_addr_next  = reg_addr_reg;
    wdata_next     = wdata_reg;
    ms_cnt_next    = ms_cnt_reg;
    delay_cnt_next = delay_cnt_reg;
    err_addr_next  = err_addr_reg;
`ifdef SCCB_RETRY_EN
    retry_cnt_next = retry_cnt_reg;
`endif

    case (state_reg)
      // start is only looked at here; once the walk begins it is ignored.
      IDLE: begin
        if (start) begin
          rom_addr_next = '0;
          state_next    = FETCH;
        end
      end

      // ROM output for the new address appears one cycle later.
      FETCH: begin
        state_next = DECODE;
      end

      // Capture the entry and start it with fresh counters.
      DECODE: begin
        reg_addr_next  = entry_addr;
        wdata_next     = entry_data;
        ms_cnt_next    = '0;
        delay_cnt_next = '0;
`ifdef SCCB_RETRY_EN
        retry_cnt_next = '0;
`endif
        if (entry_addr == END_MARK) begin
          state_next = DONE;
        end else if (entry_addr == DELAY_MARK) begin
          state_next = (entry_data == 8'd0) ? NEXT : WAIT_MS;
        end else begin
          state_next = WRITE;
        end
      end

      // Request is held until the master reports completion. Every exit
      // passes through at least one state with the request low.
      WRITE: begin
        if (sccb.sccb_done) begin
          if (!sccb.sccb_nack) begin
            state_next = NEXT;
          end else begin
`ifdef SCCB_RETRY_EN
            if (retry_cnt_reg == RETRY_LAST) begin
              err_addr_next = rom_addr_reg;
              state_next    = ERR;
            end else begin
              retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
              state_next     = RETRY_GAP;
            end
`else
            err_addr_next = rom_addr_reg;
            state_next    = ERR;
`endif
          end
        end
      end

      // One idle cycle between a NACKed attempt and its re-issue.
      RETRY_GAP: begin
        state_next = WRITE;
      end

      // ms_cnt spans one millisecond; delay_cnt counts completed ones.
      WAIT_MS: begin
        if (ms_cnt_reg == MS_LAST) begin
          ms_cnt_next = '0;
          if ({1'b0, delay_cnt_reg} + 9'd1 == {1'b0, wdata_reg}) begin
            state_next = NEXT;
          end else begin
            delay_cnt_next = delay_cnt_reg + 8'd1;
          end
        end else begin
          ms_cnt_next = ms_cnt_reg + MS_W'(1);
        end
      end

      // The last ROM address closes the table instead of wrapping to 0.
      NEXT: begin
        if (rom_addr_reg == ADDR_LAST) begin
          state_next = DONE;
        end else begin
          rom_addr_next = rom_addr_reg + ADDR_W'(1);
          state_next    = FETCH;
        end
      end

      DONE: begin
        state_next = DONE;
      end

      ERR: begin
        state_next = ERR;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state, so reset clears them at the
  // next edge and the request drops as soon as WRITE is left.
  assign rom_addr           = rom_addr_reg;
  assign sccb.sccb_req      = (state_reg == WRITE);
  assign sccb.sccb_reg_addr = reg_addr_reg;
  assign sccb.sccb_wdata    = wdata_reg;
  assign cfg_done           = (state_reg == DONE);
  assign cfg_err            = (state_reg == ERR);
  assign err_addr           = err_addr_reg;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: a ROM model, an SCCB master model with random
// response latency and a table-walking reference model that predicts the
// ordered write list, the request spacing and the final done/error outcome.
module tb_sccb_cfg_sequencer;

  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int MS_CYC    = 10;
  localparam int MAX_RETRY = 3;
  localparam int MAXQ      = 64;
`ifdef SCCB_RETRY_EN
  localparam int ALLOWED_NACKS = MAX_RETRY;
`else
  localparam int ALLOWED_NACKS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              cfg_done;
  logic              cfg_err;
  logic [ADDR_W-1:0] err_addr;

  sccb_cfg_sequencer_if sccb ();

  sccb_cfg_sequencer #(
    .ADDR_W    (ADDR_W),
    .MS_CYC    (MS_CYC),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .sccb     (sccb.master),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  // Table ROM with one cycle of read latency.
  logic [23:0] rom_mem [DEPTH];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int nack_plan [DEPTH];
  logic [15:0] exp_addr [MAXQ];
  logic [7:0]  exp_data [MAXQ];
  int          exp_glo  [MAXQ];
  int          exp_ghi  [MAXQ];
  bit          resp_nack[MAXQ];
  int exp_n = 0;
  int exp_rd = 0;
  bit exp_done, exp_err;
  int exp_err_addr;

  logic [15:0] obs_addr [MAXQ];
  logic [7:0]  obs_data [MAXQ];
  int          obs_gap  [MAXQ];
  int obs_n = 0;
  int last_evt = 0;
  bit req_prev = 1'b0;
  logic [15:0] held_addr;
  logic [7:0]  held_data;

  bit spur_en = 1'b0;
  int inj_cnt = 0;

  // SCCB master model: answers each request after 0..3 cycles using the
  // planned ACK/NACK sequence; may also emit stray done pulses while idle.
  int resp_rd = 0;
  int inj_seen = 0;
  int lat = 0;
  bit in_txn = 1'b0;
  bit responded = 1'b0;
  always @(negedge clk) begin
    sccb.sccb_done = 1'b0;
    sccb.sccb_nack = 1'b0;
    if (inj_seen != inj_cnt) begin
      inj_seen = inj_cnt;
      sccb.sccb_done = 1'b1;
      sccb.sccb_nack = 1'($urandom_range(0, 1));
    end else if (rst) begin
      resp_rd = 0;
      in_txn = 1'b0;
      responded = 1'b0;
    end else if (sccb.sccb_req) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        responded = 1'b0;
        lat = $urandom_range(0, 3);
      end
      if (!responded) begin
        if (lat == 0) begin
          sccb.sccb_done = 1'b1;
          sccb.sccb_nack = (resp_rd < MAXQ) ? resp_nack[resp_rd] : 1'b0;
          resp_rd++;
          responded = 1'b1;
        end else begin
          lat--;
        end
      end
    end else begin
      in_txn = 1'b0;
      responded = 1'b0;
      if (spur_en && $urandom_range(0, 9) == 0) begin
        sccb.sccb_done = 1'b1;
        sccb.sccb_nack = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: walk the table the way the configuration is defined and
  // list every expected write attempt with its allowed spacing (in cycles)
  // from the previous start/completion event.
  task automatic build_model();
    int  base = 3;
    int  pend = 0;
    bit  pend_delay = 1'b0;
    bit  stop = 1'b0;
    exp_n = 0;
    exp_rd = 0;
    exp_done = 1'b1;
    exp_err = 1'b0;
    exp_err_addr = 0;
    for (int i = 0; i < DEPTH && !stop; i++) begin
      logic [15:0] ra;
      logic [7:0]  rd;
      ra = rom_mem[i][23:8];
      rd = rom_mem[i][7:0];
      if (ra == 16'hFFFF) begin
        stop = 1'b1;
      end else if (ra == 16'hFFFE) begin
        pend += 3 + int'(rd) * MS_CYC;
        if (rd != 0) pend_delay = 1'b1;
      end else begin
        for (int a = 0; a <= ALLOWED_NACKS + 1; a++) begin
          bit nk;
          nk = (a < nack_plan[i]);
          exp_addr[exp_n]  = ra;
          exp_data[exp_n]  = rd;
          exp_glo[exp_n]   = base + pend - (pend_delay ? 2 : 0);
          exp_ghi[exp_n]   = base + pend + (pend_delay ? 2 : 0);
          resp_nack[exp_n] = nk;
          exp_n++;
          base = nk ? 2 : 4;
          pend = 0;
          pend_delay = 1'b0;
          if (nk && a >= ALLOWED_NACKS) begin
            exp_done = 1'b0;
            exp_err = 1'b1;
            exp_err_addr = i;
            stop = 1'b1;
            break;
          end
          if (!nk) break;
        end
      end
    end
  endtask

  // Per-cycle comparison of the SCCB request stream against the model.
  task automatic cmp_cycle();
    chk_rng("flags_exclusive", int'(cfg_done) + int'(cfg_err), 0, 1);
    if (sccb.sccb_req && !req_prev) begin
      int gap;
      gap = cyc - last_evt;
      if (obs_n < MAXQ) begin
        obs_addr[obs_n] = sccb.sccb_reg_addr;
        obs_data[obs_n] = sccb.sccb_wdata;
        obs_gap[obs_n]  = gap;
        obs_n++;
      end
      held_addr = sccb.sccb_reg_addr;
      held_data = sccb.sccb_wdata;
      if (exp_rd >= exp_n) begin
        chk("unexpected_req", {16'd0, sccb.sccb_reg_addr}, 32'hFFFF_FFFF);
      end else begin
        $display("write %0d addr=%h data=%h gap=%0d", exp_rd, sccb.sccb_reg_addr, sccb.sccb_wdata, gap);
        chk("req_addr", {16'd0, sccb.sccb_reg_addr}, {16'd0, exp_addr[exp_rd]});
        chk("req_data", {24'd0, sccb.sccb_wdata}, {24'd0, exp_data[exp_rd]});
        chk_rng("req_spacing", gap, exp_glo[exp_rd], exp_ghi[exp_rd]);
        exp_rd++;
      end
    end else if (sccb.sccb_req) begin
      chk("addr_stable", {16'd0, sccb.sccb_reg_addr}, {16'd0, held_addr});
      chk("data_stable", {24'd0, sccb.sccb_wdata}, {24'd0, held_data});
    end
    if (sccb.sccb_req && sccb.sccb_done) last_evt = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (!rst) cmp_cycle();
    req_prev = sccb.sccb_req;
  endtask

  task automatic fill_rom(input logic [23:0] v);
    for (int i = 0; i < DEPTH; i++) begin
      rom_mem[i] = v;
      nack_plan[i] = 0;
    end
  endtask

  // Start the walk from IDLE and compare the outcome with the model.
  task automatic go_run(input int bound);
    int k = 0;
    start = 1'b1;
    last_evt = cyc;
    obs_n = 0;
    while (!(cfg_done || cfg_err) && k < bound) begin
      tick();
      k++;
    end
    chk("terminal_reached", {31'd0, cfg_done | cfg_err}, 32'd1);
    repeat (4) tick();
    $display("run end done=%0b err=%0b err_addr=%0d writes=%0d", cfg_done, cfg_err, err_addr, obs_n);
    chk("final_done", {31'd0, cfg_done}, {31'd0, exp_done});
    chk("final_err", {31'd0, cfg_err}, {31'd0, exp_err});
    if (exp_err) chk("final_err_addr", {29'd0, err_addr}, 32'(exp_err_addr));
    chk("write_count", 32'(obs_n), 32'(exp_n));
    chk("final_req_low", {31'd0, sccb.sccb_req}, 32'd0);
    start = 1'b0;
    repeat (5) tick();
    chk("sticky_done", {31'd0, cfg_done}, {31'd0, exp_done});
    chk("sticky_err", {31'd0, cfg_err}, {31'd0, exp_err});
  endtask

  task automatic run_table(input int bound);
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    build_model();
    chk("rst_req", {31'd0, sccb.sccb_req}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
    chk("rst_err_addr", {29'd0, err_addr}, 32'd0);
    rst = 1'b0;
    tick();
    go_run(bound);
  endtask

  initial begin
    fill_rom(24'hFFFF00);

    // T1: two writes in table order, end marker not written.
    fill_rom(24'hFFFF00);
    rom_mem[0] = 24'h301280;
    rom_mem[1] = 24'h300842;
    run_table(500);
    chk("t1_count", 32'(obs_n), 32'd2);
    chk("t1_addr0", {16'd0, obs_addr[0]}, 32'h3012);
    chk("t1_data0", {24'd0, obs_data[0]}, 32'h80);
    chk("t1_addr1", {16'd0, obs_addr[1]}, 32'h3008);
    chk("t1_data1", {24'd0, obs_data[1]}, 32'h42);
    chk("t1_done", {31'd0, cfg_done}, 32'd1);

    // T2: 5 ms wait before the first write, zero-length wait adds no delay.
    fill_rom(24'hFFFF00);
    rom_mem[0] = 24'hFFFE05;
    rom_mem[1] = 24'h310311;
    rom_mem[2] = 24'hFFFE00;
    rom_mem[3] = 24'h310422;
    run_table(500);
    chk("t2_addr0", {16'd0, obs_addr[0]}, 32'h3103);
    chk_rng("t2_first_gap", obs_gap[0], 54, 58);
    chk("t2_zero_wait_gap", 32'(obs_gap[1]), 32'd7);
    chk("t2_done", {31'd0, cfg_done}, 32'd1);

`ifdef SCCB_RETRY_EN
    // T3: three NACKs then ACK succeeds; four NACKs fail on entry 1.
    fill_rom(24'hFFFF00);
    rom_mem[0] = 24'h300001;
    rom_mem[1] = 24'h300102;
    nack_plan[1] = 3;
    run_table(500);
    chk("t3_count", 32'(obs_n), 32'd5);
    chk("t3_retry_addr", {16'd0, obs_addr[4]}, 32'h3001);
    chk("t3_retry_gap", 32'(obs_gap[2]), 32'd2);
    chk("t3_done", {31'd0, cfg_done}, 32'd1);
    nack_plan[1] = 4;
    run_table(500);
    chk("t3b_count", 32'(obs_n), 32'd5);
    chk("t3b_err", {31'd0, cfg_err}, 32'd1);
    chk("t3b_err_addr", {29'd0, err_addr}, 32'd1);
    chk("t3b_done", {31'd0, cfg_done}, 32'd0);
`else
    // T4: first NACK on entry 2 fails immediately.
    fill_rom(24'hFFFF00);
    rom_mem[0] = 24'h300001;
    rom_mem[1] = 24'h300102;
    rom_mem[2] = 24'h300203;
    nack_plan[2] = 1;
    run_table(500);
    chk("t4_count", 32'(obs_n), 32'd3);
    chk("t4_err", {31'd0, cfg_err}, 32'd1);
    chk("t4_err_addr", {29'd0, err_addr}, 32'd2);
    chk("t4_done", {31'd0, cfg_done}, 32'd0);
`endif

    // T5: reset while a request is pending, late done ignored, clean restart.
    fill_rom(24'hFFFF00);
    rom_mem[0] = 24'h301280;
    rom_mem[1] = 24'h300842;
    rst = 1'b1;
    tick();
    tick();
    build_model();
    rst = 1'b0;
    tick();
    start = 1'b1;
    last_evt = cyc;
    obs_n = 0;
    for (int k = 0; k < 50 && !sccb.sccb_req; k++) tick();
    chk("t5_req_seen", {31'd0, sccb.sccb_req}, 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_req_cleared", {31'd0, sccb.sccb_req}, 32'd0);
    chk("t5_rom_addr", {29'd0, rom_addr}, 32'd0);
    chk("t5_reg_addr", {16'd0, sccb.sccb_reg_addr}, 32'd0);
    chk("t5_wdata", {24'd0, sccb.sccb_wdata}, 32'd0);
    chk("t5_flags", {30'd0, cfg_done, cfg_err}, 32'd0);
    inj_cnt++;
    tick();
    start = 1'b0;
    build_model();
    tick();
    rst = 1'b0;
    inj_cnt++;
    repeat (6) tick();
    chk("t5_idle_req", {31'd0, sccb.sccb_req}, 32'd0);
    chk("t5_idle_flags", {30'd0, cfg_done, cfg_err}, 32'd0);
    go_run(500);
    chk("t5_restart_addr", {16'd0, obs_addr[0]}, 32'h3012);

    // T6: full table without an end marker stops at the last address.
    fill_rom(24'hFFFF00);
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = {16'(24'h2000 + i), 8'($urandom_range(0, 255))};
    run_table(1000);
    chk("t6_count", 32'(obs_n), 32'(DEPTH));
    chk("t6_done", {31'd0, cfg_done}, 32'd1);
    chk("t6_no_wrap", {29'd0, rom_addr}, 32'(DEPTH - 1));

    // Randomized tables, delays, NACK plans and stray done pulses.
    spur_en = 1'b1;
    for (int r = 0; r < 12; r++) begin
      fill_rom(24'hFFFF00);
      for (int i = 0; i < DEPTH; i++) begin
        int sel;
        int nsel;
        sel = $urandom_range(0, 15);
        if (sel == 0) rom_mem[i] = 24'hFFFF00;
        else if (sel < 3) rom_mem[i] = {16'hFFFE, 8'($urandom_range(0, 3))};
        else rom_mem[i] = {16'($urandom_range(0, 16'hFFFD)), 8'($urandom_range(0, 255))};
        nsel = $urandom_range(0, 11);
        if (nsel < 8) nack_plan[i] = 0;
        else if (nsel < 10) nack_plan[i] = 1;
        else if (nsel == 10) nack_plan[i] = MAX_RETRY;
        else nack_plan[i] = MAX_RETRY + 1;
      end
      run_table(3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
